// File: rtl/exu_muldiv_sched_if.sv
// Dispatch-side issue handshake and regfile writeback port of the mul/div scheduler.
interface exu_muldiv_sched_if #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
);
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [2:0]      issue_op_i;
  logic [XLEN-1:0] issue_rs1_i;
  logic [XLEN-1:0] issue_rs2_i;
  logic [RAW-1:0]  issue_rd_i;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic [RAW-1:0]  wb_waddr_o;
  logic [XLEN-1:0] wb_wdata_o;

  modport slave (
    input  issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );

  modport master (
    output issue_valid_i, issue_op_i, issue_rs1_i, issue_rs2_i, issue_rd_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/exu_muldiv_sched.sv
// M-extension scheduler: one request slot per mul/div unit, shared writeback FIFO,
// per-register pending scoreboard. Outstanding count is the FIFO credit.
module exu_muldiv_sched #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int WB_DEPTH       = 4,
  parameter int DIV_FIRST      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  exu_muldiv_sched_if.slave             io,
  input  logic                          flush_i,
  output logic                          mul_valid_o,
  input  logic                          mul_ready_i,
  output logic [1:0]                    mul_op_o,
  output logic [XLEN-1:0]               mul_a_o,
  output logic [XLEN-1:0]               mul_b_o,
  output logic [REG_ADDR_WIDTH-1:0]     mul_rd_o,
  output logic                          div_valid_o,
  input  logic                          div_ready_i,
  output logic [1:0]                    div_op_o,
  output logic [XLEN-1:0]               div_a_o,
  output logic [XLEN-1:0]               div_b_o,
  output logic [REG_ADDR_WIDTH-1:0]     div_rd_o,
  input  logic                          mul_done_i,
  input  logic [XLEN-1:0]               mul_result_i,
  input  logic [REG_ADDR_WIDTH-1:0]     mul_done_rd_i,
  input  logic                          div_done_i,
  input  logic [XLEN-1:0]               div_result_i,
  input  logic [REG_ADDR_WIDTH-1:0]     div_done_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0]     rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]     rs2_addr_i,
  output logic                          rs1_pending_o,
  output logic                          rs2_pending_o,
  output logic [$clog2(WB_DEPTH):0]     outstanding_o,
  output logic                          busy_o
);
  localparam int RAW  = REG_ADDR_WIDTH;
  localparam int NREG = 1 << RAW;
  localparam int AW   = $clog2(WB_DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);
  localparam logic [CW-1:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic            mul_vld_q, mul_vld_d, div_vld_q, div_vld_d;
  logic [1:0]      mul_op_q, mul_op_d, div_op_q, div_op_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [XLEN-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [RAW-1:0]  mul_rd_q, mul_rd_d, div_rd_q, div_rd_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RAW-1:0]  fifo_rd_q   [WB_DEPTH];
  logic [RAW-1:0]  fifo_rd_d   [WB_DEPTH];
  logic [XLEN-1:0] fifo_data_q [WB_DEPTH];
  logic [XLEN-1:0] fifo_data_d [WB_DEPTH];

  logic            is_div, rd_zero, unit_free, issue_ready, accept;
  logic            mul_hand, div_hand, mul_drop, div_drop, fifo_empty, pop;
  logic            pa_v, pb_v;
  logic [RAW-1:0]  pa_rd, pb_rd;
  logic [XLEN-1:0] pa_data, pb_data;
  logic [CW-1:0]   wp;
  logic [RAW-1:0]  head_rd;

  always_comb begin
    is_div      = io.issue_op_i[2];
    rd_zero     = (io.issue_rd_i == '0);
    unit_free   = is_div ? !div_vld_q : !mul_vld_q;
    // rd==0 ops are architecturally no-ops: take them without touching any resource
    issue_ready = !flush_i && (rd_zero || ((outstanding_q < DEPTH_C) && unit_free
                                           && !pending_q[io.issue_rd_i]));
    accept      = io.issue_valid_i && issue_ready && !rd_zero;

    mul_hand    = mul_vld_q && mul_ready_i;
    div_hand    = div_vld_q && div_ready_i;
    mul_drop    = mul_vld_q && !mul_ready_i && flush_i;
    div_drop    = div_vld_q && !div_ready_i && flush_i;

    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    pop         = !fifo_empty && io.wb_ready_i;
    head_rd     = fifo_rd_q[rd_ptr_q[AW-1:0]];

    mul_vld_d = mul_vld_q;
    mul_op_d  = mul_op_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_rd_d  = mul_rd_q;
    if (mul_hand || mul_drop) mul_vld_d = 1'b0;
    if (accept && !is_div) begin
      mul_vld_d = 1'b1;
      mul_op_d  = io.issue_op_i[1:0];
      mul_a_d   = io.issue_rs1_i;
      mul_b_d   = io.issue_rs2_i;
      mul_rd_d  = io.issue_rd_i;
    end

    div_vld_d = div_vld_q;
    div_op_d  = div_op_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    div_rd_d  = div_rd_q;
    if (div_hand || div_drop) div_vld_d = 1'b0;
    if (accept && is_div) begin
      div_vld_d = 1'b1;
      div_op_d  = io.issue_op_i[1:0];
      div_a_d   = io.issue_rs1_i;
      div_b_d   = io.issue_rs2_i;
      div_rd_d  = io.issue_rd_i;
    end

    // WAW stall guarantees the set bit never collides with a cleared one
    pending_d = pending_q;
    if (pop)      pending_d[head_rd]  = 1'b0;
    if (mul_drop) pending_d[mul_rd_q] = 1'b0;
    if (div_drop) pending_d[div_rd_q] = 1'b0;
    if (accept)   pending_d[io.issue_rd_i] = 1'b1;

    outstanding_d = outstanding_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop}
                    - {{AW{1'b0}}, mul_drop} - {{AW{1'b0}}, div_drop};

    if (DIV_FIRST != 0) begin
      pa_v = div_done_i; pa_rd = div_done_rd_i; pa_data = div_result_i;
      pb_v = mul_done_i; pb_rd = mul_done_rd_i; pb_data = mul_result_i;
    end else begin
      pa_v = mul_done_i; pa_rd = mul_done_rd_i; pa_data = mul_result_i;
      pb_v = div_done_i; pb_rd = div_done_rd_i; pb_data = div_result_i;
    end

    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wp          = wr_ptr_q;
    if (pa_v) begin
      fifo_rd_d[wp[AW-1:0]]   = pa_rd;
      fifo_data_d[wp[AW-1:0]] = pa_data;
      wp = wp + ONE_C;
    end
    if (pb_v) begin
      fifo_rd_d[wp[AW-1:0]]   = pb_rd;
      fifo_data_d[wp[AW-1:0]] = pb_data;
      wp = wp + ONE_C;
    end
    wr_ptr_d = wp;
    rd_ptr_d = pop ? (rd_ptr_q + ONE_C) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_vld_q     <= 1'b0;
      mul_op_q      <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_rd_q      <= '0;
      div_vld_q     <= 1'b0;
      div_op_q      <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      div_rd_q      <= '0;
      pending_q     <= '0;
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      mul_vld_q     <= mul_vld_d;
      mul_op_q      <= mul_op_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      mul_rd_q      <= mul_rd_d;
      div_vld_q     <= div_vld_d;
      div_op_q      <= div_op_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      div_rd_q      <= div_rd_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_data_q   <= fifo_data_d;
    end
  end

  assign io.issue_ready_o = issue_ready;
  assign io.wb_valid_o    = !fifo_empty;
  assign io.wb_waddr_o    = head_rd;
  assign io.wb_wdata_o    = fifo_data_q[rd_ptr_q[AW-1:0]];

  assign mul_valid_o   = mul_vld_q;
  assign mul_op_o      = mul_op_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign mul_rd_o      = mul_rd_q;
  assign div_valid_o   = div_vld_q;
  assign div_op_o      = div_op_q;
  assign div_a_o       = div_a_q;
  assign div_b_o       = div_b_q;
  assign div_rd_o      = div_rd_q;

  assign rs1_pending_o = (rs1_addr_i != '0) && pending_q[rs1_addr_i];
  assign rs2_pending_o = (rs2_addr_i != '0) && pending_q[rs2_addr_i];
  assign outstanding_o = outstanding_q;
  assign busy_o        = (outstanding_q != '0);
endmodule
